// File: rtl/dcache_pkg.sv
// Shared encodings and helpers for the direct-mapped write-through L1 data cache.
package dcache_pkg;

    localparam int LINE_BYTES = 32;
    localparam int LINE_BITS  = LINE_BYTES * 8;

    // Access size field, type[1:0] of the LSQ op; type[2] selects zero-extension.
    localparam logic [1:0] OP_B     = 2'b00;
    localparam logic [1:0] OP_H     = 2'b01;
    localparam logic [1:0] OP_W     = 2'b10;
    localparam logic [1:0] OP_LBCMP = 2'b11;
    localparam int         OP_UNSIGNED = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STORE,
        ST_FILL_REQ,
        ST_FILL_WAIT
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == OP_H) && off[0]) || ((size == OP_W) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            OP_B:    store_be = 4'b0001 << off;
            OP_H:    store_be = 4'b0011 << {off[1], 1'b0};
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            OP_B:    store_lanes = {4{wdata[7:0]}};
            OP_H:    store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

endpackage

// File: rtl/dcache_extract.sv
// Pulls a sized, extended load value or an lbcmp byte-match mask out of one cache line.
module dcache_extract
    import dcache_pkg::*;
(
    input  logic [LINE_BITS-1:0] line_i,
    input  logic [2:0]           op_type_i,
    input  logic [4:0]           addr_i,
    input  logic [7:0]           cmp_byte_i,
    output logic [31:0]          result_o,
    output logic                 misalign_o
);

    logic [31:0] word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        uns;

    assign word       = line_i[{addr_i[4:2], 5'b00000} +: 32];
    assign byte_v     = word[{addr_i[1:0], 3'b000} +: 8];
    assign half_v     = word[{addr_i[1], 4'b0000} +: 16];
    assign uns        = op_type_i[OP_UNSIGNED];
    assign misalign_o = is_misaligned(op_type_i[1:0], addr_i[1:0]);

    always_comb begin
        result_o = '0;
        case (op_type_i[1:0])
            OP_B: result_o = uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            OP_H: begin
                if (!misalign_o) begin
                    result_o = uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
                end
            end
            OP_W: begin
                if (!misalign_o) begin
                    result_o = word;
                end
            end
            default: begin
                // lbcmp ignores the byte offset and compares every byte of the line.
                for (int i = 0; i < LINE_BYTES; i++) begin
                    result_o[i] = (line_i[8*i +: 8] == cmp_byte_i);
                end
            end
        endcase
    end

endmodule

// File: rtl/dcache.sv
// Blocking direct-mapped L1 data cache: write-through, no-write-allocate, one memory op in flight.
module dcache
    import dcache_pkg::*;
#(
    parameter int NSETS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lsq_dc_req,
    input  logic [3:0]           lsq_dc_op,
    input  logic [31:0]          lsq_dc_addr,
    input  logic [3:0]           lsq_dc_lsqid,
    input  logic [31:0]          lsq_dc_wdata,
    input  logic                 lsq_dc_flush,
    output logic                 dcache_lsq_ready,
    output logic                 dcache_lsq_valid,
    output logic                 dcache_lsq_error,
    output logic [3:0]           dcache_lsq_lsqid,
    output logic [31:0]          dcache_lsq_rdata,
    output logic                 dcache_mem_req,
    output logic                 dcache_mem_we,
    output logic [29:0]          dcache_mem_addr,
    output logic [31:0]          dcache_mem_wdata,
    output logic [3:0]           dcache_mem_be,
    input  logic                 mem_dcache_ready,
    input  logic                 mem_dcache_valid,
    input  logic [LINE_BITS-1:0] mem_dcache_rdata
);

    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = 32 - 5 - IDXW;

    logic [NSETS-1:0]     valid_q, valid_d;
    logic [TAGW-1:0]      tag_q  [NSETS];
    logic [LINE_BITS-1:0] data_q [NSETS];

    state_e      state_q, state_d;
    logic        kill_q, kill_d;
    logic [2:0]  rtype_q, rtype_d;
    logic [31:0] raddr_q, raddr_d;
    logic [3:0]  rid_q, rid_d;
    logic [7:0]  rcmp_q, rcmp_d;

    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [3:0]  resp_id_q, resp_id_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;

    logic                 req_store;
    logic [2:0]           req_type;
    logic [IDXW-1:0]      req_idx, fill_idx, arr_idx;
    logic [TAGW-1:0]      req_tag, fill_tag;
    logic                 req_hit, req_mis;
    logic [3:0]           st_be;
    logic [31:0]          st_wdata;
    logic [LINE_BITS-1:0] st_line, arr_line;
    logic                 arr_we, tag_we;

    logic                 in_fill;
    logic [LINE_BITS-1:0] ex_line;
    logic [2:0]           ex_type;
    logic [4:0]           ex_addr;
    logic [7:0]           ex_cmp;
    logic [31:0]          ex_result;
    logic                 ex_misalign;

    assign req_store = lsq_dc_op[0];
    assign req_type  = lsq_dc_op[3:1];
    assign req_idx   = lsq_dc_addr[5 +: IDXW];
    assign req_tag   = lsq_dc_addr[31 -: TAGW];
    assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign req_mis   = is_misaligned(req_type[1:0], lsq_dc_addr[1:0]);
    assign st_be     = store_be(req_type[1:0], lsq_dc_addr[1:0]);
    assign st_wdata  = store_lanes(req_type[1:0], lsq_dc_wdata);
    assign fill_idx  = raddr_q[5 +: IDXW];
    assign fill_tag  = raddr_q[31 -: TAGW];

    // One extractor serves both the IDLE hit lookup and the returning fill line.
    assign in_fill = (state_q == ST_FILL_WAIT);
    assign ex_line = in_fill ? mem_dcache_rdata : data_q[req_idx];
    assign ex_type = in_fill ? rtype_q : req_type;
    assign ex_addr = in_fill ? raddr_q[4:0] : lsq_dc_addr[4:0];
    assign ex_cmp  = in_fill ? rcmp_q : lsq_dc_wdata[7:0];

    dcache_extract u_extract (
        .line_i     (ex_line),
        .op_type_i  (ex_type),
        .addr_i     (ex_addr),
        .cmp_byte_i (ex_cmp),
        .result_o   (ex_result),
        .misalign_o (ex_misalign)
    );

    always_comb begin
        st_line = data_q[req_idx];
        for (int b = 0; b < 4; b++) begin
            if (st_be[b]) begin
                st_line[{lsq_dc_addr[4:2], 2'(b), 3'b000} +: 8] = st_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        kill_d       = kill_q;
        rtype_d      = rtype_q;
        raddr_d      = raddr_q;
        rid_d        = rid_q;
        rcmp_d       = rcmp_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        arr_we       = 1'b0;
        tag_we       = 1'b0;
        arr_idx      = req_idx;
        arr_line     = st_line;

        case (state_q)
            ST_IDLE: begin
                if (lsq_dc_req) begin
                    if (req_store) begin
                        if (!req_mis) begin
                            mem_addr_d  = lsq_dc_addr[31:2];
                            mem_wdata_d = st_wdata;
                            mem_be_d    = st_be;
                            arr_we      = req_hit;
                            state_d     = ST_STORE;
                        end
                    end else if (req_mis || req_hit) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = ex_misalign;
                        resp_id_d    = lsq_dc_lsqid;
                        resp_data_d  = ex_misalign ? 32'd0 : ex_result;
                    end else begin
                        rtype_d     = req_type;
                        raddr_d     = lsq_dc_addr;
                        rid_d       = lsq_dc_lsqid;
                        rcmp_d      = lsq_dc_wdata[7:0];
                        kill_d      = 1'b0;
                        mem_addr_d  = {lsq_dc_addr[31:5], 3'b000};
                        mem_wdata_d = '0;
                        mem_be_d    = '0;
                        state_d     = ST_FILL_REQ;
                    end
                end
            end
            ST_STORE: begin
                if (mem_dcache_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL_REQ: begin
                if (lsq_dc_flush) begin
                    kill_d = 1'b1;
                end
                if (mem_dcache_ready) begin
                    state_d = ST_FILL_WAIT;
                end
            end
            ST_FILL_WAIT: begin
                if (lsq_dc_flush) begin
                    kill_d = 1'b1;
                end
                if (mem_dcache_valid) begin
                    // The line is installed even when the response has been killed.
                    arr_we            = 1'b1;
                    tag_we            = 1'b1;
                    arr_idx           = fill_idx;
                    arr_line          = mem_dcache_rdata;
                    valid_d[fill_idx] = 1'b1;
                    resp_valid_d      = !(kill_q || lsq_dc_flush);
                    resp_err_d        = 1'b0;
                    resp_id_d         = rid_q;
                    resp_data_d       = ex_result;
                    state_d           = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            kill_q       <= 1'b0;
            rtype_q      <= '0;
            raddr_q      <= '0;
            rid_q        <= '0;
            rcmp_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            kill_q       <= kill_d;
            rtype_q      <= rtype_d;
            raddr_q      <= raddr_d;
            rid_q        <= rid_d;
            rcmp_q       <= rcmp_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && arr_we) begin
            data_q[arr_idx] <= arr_line;
        end
        if (!rst && tag_we) begin
            tag_q[arr_idx] <= fill_tag;
        end
    end

    assign dcache_lsq_ready = (state_q == ST_IDLE) && !rst;
    assign dcache_lsq_valid = resp_valid_q;
    assign dcache_lsq_error = resp_err_q;
    assign dcache_lsq_lsqid = resp_id_q;
    assign dcache_lsq_rdata = resp_data_q;
    assign dcache_mem_req   = (state_q == ST_STORE) || (state_q == ST_FILL_REQ);
    assign dcache_mem_we    = (state_q == ST_STORE);
    assign dcache_mem_addr  = mem_addr_q;
    assign dcache_mem_wdata = mem_wdata_q;
    assign dcache_mem_be    = mem_be_q;

endmodule

// File: tb/tb_dcache.sv
// Randomised and directed bench for dcache against a flat-memory reference model.
module tb_dcache;

    localparam logic [3:0] LB = 4'b0000, LH = 4'b0010, LW = 4'b0100, LCMP = 4'b0110;
    localparam logic [3:0] LBU = 4'b1000, LHU = 4'b1010;
    localparam logic [3:0] SB = 4'b0001, SH = 4'b0011, SW = 4'b0101;

    logic         clk, rst;
    logic         lsq_dc_req, lsq_dc_flush;
    logic [3:0]   lsq_dc_op, lsq_dc_lsqid;
    logic [31:0]  lsq_dc_addr, lsq_dc_wdata;
    logic         dcache_lsq_ready, dcache_lsq_valid, dcache_lsq_error;
    logic [3:0]   dcache_lsq_lsqid;
    logic [31:0]  dcache_lsq_rdata;
    logic         dcache_mem_req, dcache_mem_we;
    logic [29:0]  dcache_mem_addr;
    logic [31:0]  dcache_mem_wdata;
    logic [3:0]   dcache_mem_be;
    logic         mem_dcache_ready, mem_dcache_valid;
    logic [255:0] mem_dcache_rdata;

    dcache dut (
        .clk              (clk),
        .rst              (rst),
        .lsq_dc_req       (lsq_dc_req),
        .lsq_dc_op        (lsq_dc_op),
        .lsq_dc_addr      (lsq_dc_addr),
        .lsq_dc_lsqid     (lsq_dc_lsqid),
        .lsq_dc_wdata     (lsq_dc_wdata),
        .lsq_dc_flush     (lsq_dc_flush),
        .dcache_lsq_ready (dcache_lsq_ready),
        .dcache_lsq_valid (dcache_lsq_valid),
        .dcache_lsq_error (dcache_lsq_error),
        .dcache_lsq_lsqid (dcache_lsq_lsqid),
        .dcache_lsq_rdata (dcache_lsq_rdata),
        .dcache_mem_req   (dcache_mem_req),
        .dcache_mem_we    (dcache_mem_we),
        .dcache_mem_addr  (dcache_mem_addr),
        .dcache_mem_wdata (dcache_mem_wdata),
        .dcache_mem_be    (dcache_mem_be),
        .mem_dcache_ready (mem_dcache_ready),
        .mem_dcache_valid (mem_dcache_valid),
        .mem_dcache_rdata (mem_dcache_rdata)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int resp_cnt = 0;
    logic [36:0] exp_q[$];   // {lsqid, error, rdata}
    logic [29:0] rd_q[$];    // expected line-read word addresses
    logic [65:0] wr_q[$];    // {word addr, wdata, be}
    logic [31:0] ref_mem  [4096];
    logic [31:0] phys_mem [4096];
    logic        mvalid [64];
    logic [20:0] mtag   [64];
    bit          hold_fill = 0;
    int          fill_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result of a load/lbcmp, taken straight from the flat memory image.
    function automatic logic [36:0] model_load(input logic [2:0] t, input logic [31:0] a,
                                               input logic [3:0] id, input logic [7:0] cmp);
        logic [31:0] w, r;
        logic        err;
        err = (t[1:0] == 2'd1 && a[0]) || (t[1:0] == 2'd2 && a[1:0] != 2'd0);
        w   = ref_mem[a[13:2]];
        r   = 0;
        if (!err) begin
            case (t[1:0])
                2'd0: begin
                    r = (w >> (8 * a[1:0])) & 32'hFF;
                    if (!t[2] && r[7]) r = r | 32'hFFFFFF00;
                end
                2'd1: begin
                    r = (w >> (8 * a[1:0])) & 32'hFFFF;
                    if (!t[2] && r[15]) r = r | 32'hFFFF0000;
                end
                2'd2: r = w;
                default: begin
                    for (int i = 0; i < 32; i++) begin
                        logic [31:0] lw;
                        lw   = ref_mem[{a[13:5], 3'(i / 4)}];
                        r[i] = (((lw >> (8 * (i % 4))) & 32'hFF) == {24'b0, cmp});
                    end
                end
            endcase
        end
        return {id, err, r};
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [3:0] id,
                         input logic [31:0] wd, input bit want_resp);
        logic [2:0]  t;
        logic [5:0]  idx;
        logic [3:0]  be;
        logic [31:0] data;
        bit          mis, hit, imm;
        int          n;
        t   = op[3:1];
        idx = a[10:5];
        mis = (t[1:0] == 2'd1 && a[0]) || (t[1:0] == 2'd2 && a[1:0] != 2'd0);
        hit = mvalid[idx] && (mtag[idx] == a[31:11]);
        n = 0;
        while (!dcache_lsq_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", dcache_lsq_ready, 1);
        if (op[0]) begin
            if (!mis) begin
                if (t[1:0] == 2'd0) begin
                    be = 4'b0001 << a[1:0];
                    data = {24'b0, wd[7:0]} * 32'h01010101;
                end else if (t[1:0] == 2'd1) begin
                    be = 4'b0011 << a[1:0];
                    data = {16'b0, wd[15:0]} * 32'h00010001;
                end else begin
                    be = 4'hF;
                    data = wd;
                end
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a[13:2]][8*b +: 8] = data[8*b +: 8];
                wr_q.push_back({a[31:2], data, be});
            end
        end else begin
            if (!mis && !hit) begin
                rd_q.push_back({a[31:5], 3'b000});
                mvalid[idx] = 1;
                mtag[idx]   = a[31:11];
            end
            if (want_resp) exp_q.push_back(model_load(t, a, id, wd[7:0]));
        end
        imm = !op[0] && (mis || hit);
        lsq_dc_req   = 1;
        lsq_dc_op    = op;
        lsq_dc_addr  = a;
        lsq_dc_lsqid = id;
        lsq_dc_wdata = wd;
        @(negedge clk);
        lsq_dc_req = 0;
        check("resp_latency", dcache_lsq_valid, imm);
    endtask

    // ---------------- response monitor ----------------
    initial forever begin
        @(negedge clk);
        if (!rst && dcache_lsq_valid) begin
            logic [36:0] e;
            resp_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("resp_id", dcache_lsq_lsqid, e[36:33]);
                check("resp_err", dcache_lsq_error, e[32]);
                check("resp_data", dcache_lsq_rdata, e[31:0]);
            end
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        bit          acc_pend, acc_we, fill_pend;
        logic [29:0] acc_addr, fill_addr;
        logic [31:0] acc_wdata;
        logic [3:0]  acc_be;
        int          fill_dly;
        acc_pend = 0; fill_pend = 0; fill_dly = 0;
        acc_we = 0; acc_addr = 0; acc_wdata = 0; acc_be = 0; fill_addr = 0;
        mem_dcache_ready = 0;
        mem_dcache_valid = 0;
        mem_dcache_rdata = '0;
        forever begin
            @(negedge clk);
            if (acc_pend) begin
                acc_pend = 0;
                if (acc_we) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        logic [65:0] e;
                        e = wr_q.pop_front();
                        check("wr_addr", acc_addr, e[65:36]);
                        check("wr_data", acc_wdata, e[35:4]);
                        check("wr_be", acc_be, e[3:0]);
                    end
                    for (int b = 0; b < 4; b++)
                        if (acc_be[b]) phys_mem[acc_addr[11:0]][8*b +: 8] = acc_wdata[8*b +: 8];
                end else begin
                    if (rd_q.size() == 0) check("unexpected_read", 1, 0);
                    else check("rd_addr", acc_addr, rd_q.pop_front());
                    fill_pend = 1;
                    fill_addr = acc_addr;
                    fill_dly  = $urandom_range(0, 3);
                end
            end
            mem_dcache_valid = 0;
            if (fill_pend && !hold_fill) begin
                if (fill_dly == 0) begin
                    for (int w = 0; w < 8; w++)
                        mem_dcache_rdata[32*w +: 32] = phys_mem[{fill_addr[11:3], 3'(w)}];
                    mem_dcache_valid = 1;
                    fill_pend = 0;
                    fill_cyc  = cyc;
                end else begin
                    fill_dly--;
                end
            end
            mem_dcache_ready = 0;
            if (dcache_mem_req && $urandom_range(0, 2) != 0) begin
                mem_dcache_ready = 1;
                acc_pend  = 1;
                acc_we    = dcache_mem_we;
                acc_addr  = dcache_mem_addr;
                acc_wdata = dcache_mem_wdata;
                acc_be    = dcache_mem_be;
            end
        end
    end

    // ---------------- main sequence ----------------
    logic [3:0] ops [9] = '{LB, LBU, LH, LHU, LW, LCMP, SB, SH, SW};
    logic [8:0] pool [24];

    initial begin
        int n, r0;
        lsq_dc_req = 0; lsq_dc_op = 0; lsq_dc_addr = 0; lsq_dc_lsqid = 0;
        lsq_dc_wdata = 0; lsq_dc_flush = 0;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = $urandom;
        end
        ref_mem[12'h400] = 32'hDEADBEEF;
        for (int k = 1; k < 7; k++) ref_mem[12'h400 + k] = 32'h01020304 + k * 32'h10101010;
        ref_mem[12'h407] = 32'hEF1C1D1E;
        for (int i = 0; i < 4096; i++) phys_mem[i] = ref_mem[i];
        for (int i = 0; i < 64; i++) begin
            mvalid[i] = 0;
            mtag[i]   = 0;
        end

        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_ready", dcache_lsq_ready, 0);
        check("rst_mem_req", dcache_mem_req, 0);
        check("rst_valid", dcache_lsq_valid, 0);
        rst = 0;
        @(negedge clk);
        check("post_rst_ready", dcache_lsq_ready, 1);
        check("post_rst_outs", {dcache_lsq_error, dcache_lsq_lsqid, dcache_lsq_rdata,
                                dcache_mem_we, dcache_mem_be, dcache_mem_addr}, 0);

        // cold load miss
        issue(LW, 32'h1000, 4'd3, 0, 1);
        check("t1_ready_low", dcache_lsq_ready, 0);
        check("t1_mem_req", dcache_mem_req, 1);
        check("t1_mem_we", dcache_mem_we, 0);
        check("t1_mem_addr", dcache_mem_addr, 30'h400);
        n = 0;
        while (!dcache_lsq_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t1_valid", dcache_lsq_valid, 1);
        check("t1_latency", cyc, fill_cyc + 1);
        check("t1_id", dcache_lsq_lsqid, 4'd3);
        check("t1_data", dcache_lsq_rdata, 32'hDEADBEEF);

        // back-to-back byte hits
        issue(LB, 32'h1003, 4'd5, 0, 1);
        check("t2_lb", dcache_lsq_rdata, 32'hFFFFFFDE);
        check("t2_lb_id", dcache_lsq_lsqid, 4'd5);
        issue(LBU, 32'h1003, 4'd6, 0, 1);
        check("t2_lbu", dcache_lsq_rdata, 32'h000000DE);
        check("t2_no_mem", dcache_mem_req, 0);

        // store byte, write-through and hit update
        issue(SB, 32'h1001, 4'd0, 32'h55, 1);
        check("t3_mem_req", dcache_mem_req, 1);
        check("t3_mem_we", dcache_mem_we, 1);
        check("t3_mem_addr", dcache_mem_addr, 30'h400);
        check("t3_mem_be", dcache_mem_be, 4'b0010);
        check("t3_mem_wdata", dcache_mem_wdata, 32'h55555555);
        issue(LW, 32'h1000, 4'd9, 0, 1);
        check("t3_lw", dcache_lsq_rdata, 32'hDEAD55EF);

        // misaligned half
        issue(LH, 32'h1001, 4'd2, 0, 1);
        check("t4_err", dcache_lsq_error, 1);
        check("t4_id", dcache_lsq_lsqid, 4'd2);
        check("t4_data", dcache_lsq_rdata, 0);
        check("t4_no_mem", dcache_mem_req, 0);

        // lbcmp on resident line
        issue(LCMP, 32'h1010, 4'd1, 32'hEF, 1);
        check("t5_mask", dcache_lsq_rdata, 32'h80000001);

        // flush while the fill is outstanding
        hold_fill = 1;
        issue(LW, 32'h2040, 4'd7, 0, 0);
        n = 0;
        while (dcache_mem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_fill_accepted", dcache_mem_req, 0);
        lsq_dc_flush = 1;
        @(negedge clk);
        lsq_dc_flush = 0;
        r0 = resp_cnt;
        hold_fill = 0;
        repeat (10) @(negedge clk);
        check("t6_killed", resp_cnt - r0, 0);
        check("t6_idle", dcache_lsq_ready, 1);
        issue(LW, 32'h2040, 4'd8, 0, 1);
        check("t6_hit_data", dcache_lsq_rdata, ref_mem[12'h810]);

        // random traffic over a small, aliasing line pool
        for (int i = 0; i < 24; i++) pool[i] = 9'($urandom_range(0, 511));
        pool[0] = 9'h080;
        for (int k = 0; k < 400; k++) begin
            logic [3:0]  op;
            logic [4:0]  off;
            logic [31:0] a, wd;
            int          bsel;
            op  = ops[$urandom_range(0, 8)];
            off = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) begin
                if (op[2:1] == 2'd1) off[0] = 0;
                if (op[2:1] == 2'd2) off[1:0] = 0;
            end
            a  = {18'b0, pool[$urandom_range(0, 23)], off};
            wd = $urandom;
            if (op == LCMP && $urandom_range(0, 1) == 1) begin
                logic [31:0] w;
                w    = ref_mem[{a[13:5], 3'($urandom_range(0, 7))}];
                bsel = $urandom_range(0, 3);
                wd[7:0] = w[8*bsel +: 8];
            end
            issue(op, a, 4'($urandom_range(0, 15)), wd, 1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        n = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0 || !dcache_lsq_ready)
               && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("drain_resp", exp_q.size(), 0);
        check("drain_reads", rd_q.size(), 0);
        check("drain_writes", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
